// File: rtl/uart_fifo_tx_pkg.sv
// uart_fifo_tx_pkg: shared constants for the memory-mapped UART transmitter.
// Holds the register word offsets, LSR/CTRL bit positions, parity-mode
// encodings, FSM state encodings and the CTRL register layout.
package uart_fifo_tx_pkg;

  localparam int          WORD_LEN  = 32;
  localparam logic [31:0] UART_ADDR = 32'h1000_0000;

  // Register word offsets (addr_d_mem[3:2])
  localparam logic [1:0] UART_THR  = 2'd0;
  localparam logic [1:0] UART_LSR  = 2'd1;
  localparam logic [1:0] UART_DIV  = 2'd2;
  localparam logic [1:0] UART_CTRL = 2'd3;

  // LSR bit positions
  localparam int LSR_TX_IDLE   = 0;
  localparam int LSR_FULL      = 1;
  localparam int LSR_EMPTY     = 2;
  localparam int LSR_OVF       = 3;
  localparam int LSR_LEVEL_LSB = 8;

  // CTRL field positions
  localparam int CTRL_TX_EN       = 0;
  localparam int CTRL_PAR_LSB     = 1;
  localparam int CTRL_STOP2       = 3;
  localparam int CTRL_IE_EMPTY    = 4;
  localparam int CTRL_IE_THR      = 5;
  localparam int CTRL_THR_LVL_LSB = 8;

  // Parity modes; 2'b11 behaves as none
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef struct packed {
    logic [7:0] thr_lvl;
    logic       ie_thr;
    logic       ie_empty;
    logic       stop2;
    logic [1:0] par;
    logic       tx_en;
  } ctrl_t;

  function automatic logic parity_on(input logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// uart_fifo_tx_if: data-memory bus port of the UART.
//   wen_mem/ren_mem : single-cycle write/read strobes (master -> slave)
//   addr_d_mem      : byte address (master -> slave)
//   wdata_mem       : write data (master -> slave)
//   rdata_uart      : registered read data (slave -> master)
// Handshake: there is no ready; a strobe high at a rising edge is always
// accepted at that edge. Read data is valid from that edge until the next
// accepted read.
interface uart_fifo_tx_if;
  import uart_fifo_tx_pkg::*;

  logic                wen_mem;
  logic                ren_mem;
  logic [WORD_LEN-1:0] addr_d_mem;
  logic [WORD_LEN-1:0] wdata_mem;
  logic [WORD_LEN-1:0] rdata_uart;

  modport master (output wen_mem, ren_mem, addr_d_mem, wdata_mem, input rdata_uart);
  modport slave  (input wen_mem, ren_mem, addr_d_mem, wdata_mem, output rdata_uart);
endinterface

// File: rtl/uart_fifo_tx_fifo.sv
// uart_sync_fifo: single-clock FIFO with push/pop/full/empty/level.
//   push/push_data : write request; accepted when not full or popping too
//   pop/pop_data   : pop_data shows the head entry whenever not empty
//   full/empty     : status flags, derived from the registered level
//   level          : entry count 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_acc, pop_acc;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_acc  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc = push && (!full || pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: memory-mapped UART transmitter with TX FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : data-memory bus (THR/LSR/DIV/CTRL at BASE_ADDR)
//   intr       : registered level interrupt (empty / threshold)
//   uart_out   : serial line, idle high
//   dbg_state  : current FSM state
module uart_fifo_tx
  import uart_fifo_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = UART_ADDR,
  parameter int          DATA_BITS   = 8,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 867
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_fifo_tx_if.slave       bus,
  output logic                intr,
  output logic                uart_out,
  output logic [2:0]          dbg_state
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     baud_q, baud_d, div_q, div_d, cur_div_q, cur_div_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           cur_par_q, cur_par_d;
  logic                 cur_stop2_q, cur_stop2_d, par_bit_q, par_bit_d;
  logic                 tx_q, tx_d, ovf_q, ovf_d, intr_q, intr_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [WORD_LEN-1:0]  rdata_q, rdata_d;

  logic                 sel, push, pop, full, empty, tx_idle, bit_done, can_start, load;
  logic [1:0]           off;
  logic [LVL_W-1:0]     level;
  logic [7:0]           level8;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 unused_bits;

  assign sel         = (bus.addr_d_mem[31:4] == BASE_ADDR[31:4]);
  assign off         = bus.addr_d_mem[3:2];
  assign unused_bits = ^{bus.addr_d_mem[1:0], bus.wdata_mem};
  assign level8      = 8'(level);
  assign tx_idle     = empty && (state_q == ST_IDLE);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.wdata_mem[DATA_BITS-1:0]),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Register writes and reads.
  always_comb begin
    div_d   = div_q;
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    push    = 1'b0;
    if (sel && bus.wen_mem) begin
      case (off)
        UART_THR: begin
          push = 1'b1;
          if (full && !pop) ovf_d = 1'b1;
        end
        UART_LSR:  if (bus.wdata_mem[LSR_OVF]) ovf_d = 1'b0;
        UART_DIV:  div_d = bus.wdata_mem[DIV_W-1:0];
        default: begin
          ctrl_d.tx_en    = bus.wdata_mem[CTRL_TX_EN];
          ctrl_d.par      = bus.wdata_mem[CTRL_PAR_LSB +: 2];
          ctrl_d.stop2    = bus.wdata_mem[CTRL_STOP2];
          ctrl_d.ie_empty = bus.wdata_mem[CTRL_IE_EMPTY];
          ctrl_d.ie_thr   = bus.wdata_mem[CTRL_IE_THR];
          ctrl_d.thr_lvl  = bus.wdata_mem[CTRL_THR_LVL_LSB +: 8];
        end
      endcase
    end
    if (sel && bus.ren_mem) begin
      rdata_d = '0;
      case (off)
        UART_THR: rdata_d = '0;
        UART_LSR: begin
          rdata_d[LSR_TX_IDLE]          = tx_idle;
          rdata_d[LSR_FULL]             = full;
          rdata_d[LSR_EMPTY]            = empty;
          rdata_d[LSR_OVF]              = ovf_q;
          rdata_d[LSR_LEVEL_LSB +: 8]   = level8;
        end
        UART_DIV: rdata_d = WORD_LEN'(div_q);
        default: begin
          rdata_d[CTRL_TX_EN]            = ctrl_q.tx_en;
          rdata_d[CTRL_PAR_LSB +: 2]     = ctrl_q.par;
          rdata_d[CTRL_STOP2]            = ctrl_q.stop2;
          rdata_d[CTRL_IE_EMPTY]         = ctrl_q.ie_empty;
          rdata_d[CTRL_IE_THR]           = ctrl_q.ie_thr;
          rdata_d[CTRL_THR_LVL_LSB +: 8] = ctrl_q.thr_lvl;
        end
      endcase
    end
    intr_d = (ctrl_q.ie_empty & tx_idle) | (ctrl_q.ie_thr & (level8 <= ctrl_q.thr_lvl));
  end

  // Transmit FSM. The frame format is latched at the pop so that register
  // writes during a frame only affect the following frame.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    cur_div_d   = cur_div_q;
    cur_par_d   = cur_par_q;
    cur_stop2_d = cur_stop2_q;
    par_bit_d   = par_bit_q;
    pop         = 1'b0;
    load        = 1'b0;
    bit_done    = (baud_q == cur_div_q);
    can_start   = ctrl_q.tx_en && !empty;
    if (state_q != ST_IDLE) baud_d = bit_done ? '0 : baud_q + DIV_W'(1);
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_start) load = 1'b1;
      end
      ST_START: if (bit_done) begin
        state_d = ST_DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      ST_DATA: if (bit_done) begin
        if (bit_q == 3'(DATA_BITS - 1)) begin
          bit_d = '0;
          if (parity_on(cur_par_q)) begin
            state_d = ST_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_PARITY: if (bit_done) begin
        state_d = ST_STOP;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      ST_STOP: if (bit_done) begin
        if (cur_stop2_q && (bit_q == 3'd0)) bit_d = 3'd1;
        else if (can_start)                 load  = 1'b1;
        else                                state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      pop         = 1'b1;
      state_d     = ST_START;
      baud_d      = '0;
      tx_d        = 1'b0;
      shift_d     = fifo_dout;
      cur_div_d   = div_q;
      cur_par_d   = ctrl_q.par;
      cur_stop2_d = ctrl_q.stop2;
      par_bit_d   = (^fifo_dout) ^ (ctrl_q.par == PAR_ODD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      cur_div_q   <= '0;
      cur_par_q   <= PAR_NONE;
      cur_stop2_q <= 1'b0;
      par_bit_q   <= 1'b0;
      div_q       <= DIV_W'(DEFAULT_DIV);
      ctrl_q      <= '{thr_lvl: 8'd0, ie_thr: 1'b0, ie_empty: 1'b0, stop2: 1'b0,
                       par: PAR_NONE, tx_en: 1'b1};
      ovf_q       <= 1'b0;
      rdata_q     <= '0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      cur_div_q   <= cur_div_d;
      cur_par_q   <= cur_par_d;
      cur_stop2_q <= cur_stop2_d;
      par_bit_q   <= par_bit_d;
      div_q       <= div_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      rdata_q     <= rdata_d;
      intr_q      <= intr_d;
    end
  end

  assign bus.rdata_uart = rdata_q;
  assign intr           = intr_q;
  assign uart_out       = tx_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: self-checking bench for uart_fifo_tx (FIFO_DEPTH=4,
// DEFAULT_DIV=10). A serial monitor decodes frames on uart_out and compares
// them against bytes queued in exp_q when THR writes are accepted.
module tb_uart_fifo_tx;
  import uart_fifo_tx_pkg::*;

  localparam int unsigned DEF_DIV = 10;

  logic       clk;
  logic       rst_n;
  logic       intr;
  logic       uart_out;
  logic [2:0] dbg_state;

  uart_fifo_tx_if bus_if ();

  uart_fifo_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .intr      (intr),
    .uart_out  (uart_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
    bus_if.addr_d_mem = UART_ADDR + 32'({off, 2'b00});
    bus_if.wdata_mem  = data;
    bus_if.wen_mem    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.wen_mem    = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
    bus_if.addr_d_mem = UART_ADDR + 32'({off, 2'b00});
    bus_if.ren_mem    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.ren_mem    = 1'b0;
    data              = bus_if.rdata_uart;
  endtask

  task automatic send(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(UART_THR, 32'(b));
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_gaps(input int n, input int flen);
    check("frame_count", 32'(start_q.size()), 32'(n));
    for (int i = 1; i < start_q.size(); i++)
      check("frame_gap", 32'(start_q[i] - start_q[i-1]), 32'(flen));
  endtask

  // ---------------- serial monitor ----------------
  int         mon_div   = 10;
  int         mon_par   = 0;   // 0 none, 1 even, 2 odd
  logic       mon_stop2 = 1'b0;
  int         mon_d, mon_p, mon_nb, mon_wait;
  logic       mon_abort;
  logic [15:0] mon_smp;
  logic [7:0] mon_byte, mon_exp;

  always begin
    @(negedge clk);
    if (rst_n && (uart_out == 1'b0)) begin
      start_q.push_back(cyc);
      mon_d     = mon_div;
      mon_p     = (mon_par != 0) ? 1 : 0;
      mon_nb    = 10 + mon_p + (mon_stop2 ? 1 : 0);
      mon_abort = 1'b0;
      mon_smp   = '0;
      for (int i = 0; i < mon_nb; i++) begin
        mon_wait = (i == 0) ? (mon_d / 2) : (mon_d + 1);
        for (int k = 0; k < mon_wait; k++) begin
          @(negedge clk);
          if (!rst_n) mon_abort = 1'b1;
        end
        mon_smp[i] = uart_out;
      end
      for (int k = 0; k < mon_d - mon_d / 2; k++) begin
        @(negedge clk);
        if (!rst_n) mon_abort = 1'b1;
      end
      if (!mon_abort) begin
        for (int j = 0; j < 8; j++) mon_byte[j] = mon_smp[1 + j];
        check("rx_start", 32'(mon_smp[0]), 32'h0);
        check("rx_pending", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("rx_data", 32'(mon_byte), 32'(mon_exp));
          if (mon_p == 1)
            check("rx_parity", 32'(mon_smp[9]), 32'((^mon_exp) ^ (mon_par == 2)));
        end
        check("rx_stop", 32'(mon_smp[9 + mon_p]), 32'h1);
        if (mon_stop2) check("rx_stop2", 32'(mon_smp[10 + mon_p]), 32'h1);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;

  initial begin
    int n;
    rst_n             = 1'b0;
    bus_if.wen_mem    = 1'b0;
    bus_if.ren_mem    = 1'b0;
    bus_if.addr_d_mem = '0;
    bus_if.wdata_mem  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_uart_out", 32'(uart_out), 32'h1);
    check("rst_intr", 32'(intr), 32'h0);
    check("rst_rdata", bus_if.rdata_uart, 32'h0);
    bus_read(UART_LSR, rd);  check("rst_lsr", rd, 32'h5);
    bus_read(UART_DIV, rd);  check("rst_div", rd, 32'(DEF_DIV));
    bus_read(UART_CTRL, rd); check("rst_ctrl", rd, 32'h1);
    bus_read(UART_THR, rd);  check("thr_read", rd, 32'h0);

    // T1: DIV=3, 8N1, 0x55 with write-to-line latency
    bus_write(UART_DIV, 32'd3);
    mon_div = 3; mon_par = 0; mon_stop2 = 1'b0;
    send(8'h55);
    @(negedge clk); check("lat_before_pop", 32'(uart_out), 32'h1);
    @(negedge clk); check("lat_start_low", 32'(uart_out), 32'h0);
    repeat (3) @(negedge clk); check("start_last_cycle", 32'(uart_out), 32'h0);
    @(negedge clk); check("bit0_first_cycle", 32'(uart_out), 32'h1);
    repeat (4) @(negedge clk); check("bit1_first_cycle", 32'(uart_out), 32'h0);
    wait_drain(200);
    bus_read(UART_LSR, rd); check("t1_lsr_idle", rd, 32'h5);

    // T2: DIV=1, even parity, two stops; back-to-back frames of 24 cycles
    bus_write(UART_DIV, 32'd1);
    bus_write(UART_CTRL, 32'h0B);
    mon_div = 1; mon_par = 1; mon_stop2 = 1'b1;
    start_q.delete();
    send(8'h07);
    send(8'hA3);
    wait_drain(200);
    check_gaps(2, 24);
    check("t2_line_high", 32'(uart_out), 32'h1);
    bus_write(UART_CTRL, 32'h01);
    mon_par = 0; mon_stop2 = 1'b0;

    // T3: fill with TX disabled, overflow, clear OVF, then drain back-to-back
    bus_write(UART_DIV, 32'd0);
    mon_div = 0;
    bus_write(UART_CTRL, 32'h00);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h11 * (i + 1)));
      bus_write(UART_THR, 32'(8'h11 * (i + 1)));
    end
    bus_read(UART_LSR, rd); check("t3_lsr_full_ovf", rd, 32'h0000_040A);
    bus_write(UART_LSR, 32'h8);
    bus_read(UART_LSR, rd); check("t3_lsr_ovf_clr", rd, 32'h0000_0402);
    start_q.delete();
    bus_write(UART_CTRL, 32'h01);
    wait_drain(300);
    check_gaps(4, 10);

    // T5: push and pop in the same cycle while full, DIV=0
    bus_write(UART_CTRL, 32'h00);
    for (int i = 0; i < 4; i++) send(8'(8'hA1 + i));
    start_q.delete();
    bus_write(UART_CTRL, 32'h01);
    send(8'hA5);
    bus_read(UART_LSR, rd); check("t5_lsr_pushpop", rd, 32'h0000_0402);
    repeat (2) @(negedge clk);
    check("rdata_hold", bus_if.rdata_uart, 32'h0000_0402);
    wait_drain(300);
    check_gaps(5, 10);

    // T4: threshold and empty interrupts, DIV=1 8N1 (20-cycle frames)
    bus_write(UART_DIV, 32'd1);
    mon_div = 1;
    bus_write(UART_CTRL, 32'h0120);
    send(8'h3A); send(8'h5B); send(8'h7C);
    repeat (2) @(negedge clk);
    check("t4_intr_lvl3", 32'(intr), 32'h0);
    bus_write(UART_CTRL, 32'h0121);
    n = 0;
    do begin @(negedge clk); n++; end while (uart_out && n < 10);
    check("t4_first_start", 32'(uart_out), 32'h0);
    check("t4_intr_lvl2", 32'(intr), 32'h0);
    repeat (20) @(negedge clk);
    check("t4_second_start", 32'(uart_out), 32'h0);
    check("t4_intr_pre_rise", 32'(intr), 32'h0);
    @(negedge clk);
    check("t4_intr_thr_rise", 32'(intr), 32'h1);
    bus_write(UART_CTRL, 32'h0111);
    repeat (2) @(negedge clk);
    check("t4_intr_busy", 32'(intr), 32'h0);
    wait_drain(200);
    for (int i = 0; i < 3; i++) begin
      check("t4_intr_empty", 32'(intr), 32'h1);
      @(negedge clk);
    end
    bus_write(UART_CTRL, 32'h01);

    // T6: reset in the middle of DATA
    bus_write(UART_DIV, 32'd3);
    mon_div = 3;
    send(8'h81);
    send(8'h42);
    n = 0;
    do begin @(negedge clk); n++; end while (uart_out && n < 10);
    repeat (10) @(negedge clk);
    check("t6_pre_rst_low", 32'(uart_out), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_line_high", 32'(uart_out), 32'h1);
    check("t6_rst_intr", 32'(intr), 32'h0);
    check("t6_rst_rdata", bus_if.rdata_uart, 32'h0);
    repeat (3) @(negedge clk);
    mon_div = int'(DEF_DIV);
    rst_n   = 1'b1;
    exp_q.delete();
    repeat (50) @(negedge clk);
    bus_read(UART_LSR, rd); check("t6_lsr_after_rst", rd, 32'h5);
    bus_read(UART_DIV, rd); check("t6_div_after_rst", rd, 32'(DEF_DIV));
    send(8'h3C);
    wait_drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Memory-mapped UART transmitter with a parametrised TX FIFO, programmable baud divisor, and programmable frame format (data bits, parity, stop bits). It sits on the core's data-memory write/read path at `BASE_ADDR` and drives the serial line `uart_out`. It raises a level interrupt on FIFO-empty/threshold conditions, replacing busy-polling of a single holding register.

## Interface
Parameters:
- `BASE_ADDR`, default `` `UART_ADDR ``: word-aligned base of the 16-byte register window.
- `DATA_BITS`, default 8: frame payload width, legal range 5..8.
- `FIFO_DEPTH`, default 16: TX FIFO entries; must be a power of 2, at least 2.
- `DIV_W`, default 16: baud divisor width.
- `DEFAULT_DIV`, default 867: reset value of DIV.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wen_mem`  in  1: bus write strobe.
- `ren_mem`  in  1: bus read strobe.
- `addr_d_mem`  in  `` `WORD_LEN ``: byte address.
- `wdata_mem`  in  `` `WORD_LEN ``: write data.
- `rdata_uart`  out  `` `WORD_LEN ``: read data, registered.
- `intr`  out  1: level interrupt, registered.
- `uart_out`  out  1: serial TX line, idle high.

## Operation
- Decode: selected when `addr_d_mem[31:4] == BASE_ADDR[31:4]`; offset is `addr_d_mem[3:2]`. Accesses are word-wide.
- 0x0 THR (write only):
  - Pushes `wdata_mem[DATA_BITS-1:0]`.
  - If the FIFO is full with no pop in the same cycle, the data is dropped and sticky OVF is set.
  - Reads return 0.
- 0x4 LSR (read):
  - bit0 TX_IDLE (FIFO empty and FSM in IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF.
  - bits[15:8] LEVEL: entry count, zero-extended.
  - Writing 1 to bit3 clears OVF. Other bits are read-only.
- 0x8 DIV (R/W), bits[DIV_W-1:0]: each bit lasts DIV+1 cycles. DIV=0 is legal (1 cycle per bit).
- 0xC CTRL (R/W):
  - bit0 TX_EN.
  - bits[2:1] PAR: 00 none, 01 even, 10 odd, 11 treated as none.
  - bit3 STOP2.
  - bit4 IE_EMPTY.
  - bit5 IE_THR.
  - bits[15:8] THR_LVL.
  - Reset value: TX_EN=1, all other bits 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START: when TX_EN and FIFO not empty. The FIFO pops, and the shifter, DIV, PAR and STOP2 are latched.
  - START→DATA.
  - DATA→DATA: repeats for DATA_BITS bits, LSB first.
  - DATA→PARITY: when PAR is even or odd. Otherwise DATA→STOP.
  - STOP: lasts 1 or 2 bit periods.
  - STOP→START directly: when TX_EN and FIFO not empty (back-to-back frames, no idle gap). Otherwise STOP→IDLE.
- Parity bit: XOR of the data bits for even, its inverse for odd.
- `intr` is registered next cycle from: (IE_EMPTY & TX_IDLE) | (IE_THR & LEVEL <= THR_LVL).
- Clearing TX_EN mid-frame: the current frame completes and no further pop occurs.
- Writes to DIV/CTRL mid-frame affect only the next frame.

## Timing
- Reset values:
  - `uart_out`=1, `intr`=0, `rdata_uart`=0.
  - FIFO empty, OVF=0, DIV=DEFAULT_DIV, FSM IDLE.
  - Reset asserted mid-frame forces `uart_out` high immediately and discards the FIFO.
- Read latency: `rdata_uart` is valid the cycle after the edge sampling `ren_mem`. It holds its value when no read occurs.
- Write-to-line latency: a THR write is sampled at edge E into an empty FIFO with the FSM idle. The pop occurs at E+1, and `uart_out` is low from E+1 for DIV+1 cycles.
- Frame length in cycles: (DIV+1)·(1+DATA_BITS+P+S), where P = 1 if parity is on (else 0) and S = 1 or 2.
- Push and pop in the same cycle: both take effect; LEVEL is unchanged. When full, the push is accepted only if a pop occurs that cycle.
- LEVEL and flags update on the edge after the push or pop. LEVEL counts 0..FIFO_DEPTH and needs clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

## Structure
- `consts.vh` additions:
  - Register offsets `UART_THR`, `UART_LSR`, `UART_DIV`, `UART_CTRL`.
  - LSR bit positions.
  - CTRL field positions.
  - Parity-mode encodings.
  - FSM state encodings.
- One sub-module, `uart_sync_fifo`:
  - Parametrised width/depth, with push/pop/full/empty/level.
  - Reset: `rst_n` async.
- Register decode, FSM, baud counter and bit counter stay in `uart_fifo_tx`.

## Test plan
- Defaults with DIV=3: write 0x55 → `uart_out` low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. TX_IDLE reads 1 afterwards.
- DIV=1, PAR=even, STOP2: write 0x07 → start, 1,1,1,0,0,0,0,0, parity 1, then two stop periods. Total 24 cycles, line high after.
- FIFO_DEPTH=4, TX_EN=0: write 6 bytes → LEVEL=4, FULL=1, OVF=1. Write 0x8 to LSR → OVF=0. Set TX_EN → 4 frames back-to-back with no idle gap.
- IE_THR=1, THR_LVL=1, 3 entries queued: `intr` rises one cycle after LEVEL drops to 1. With IE_EMPTY=1, `intr` stays high once TX_IDLE=1.
- Simultaneous push and pop at full, DIV=0: LEVEL stays at FIFO_DEPTH, OVF stays 0, no data lost (checked by order of serialised bytes).
- Reset asserted mid-DATA: `uart_out`=1 asynchronously, LEVEL=0, DIV=DEFAULT_DIV. The first frame after release is correct.
